sqrt_hs: RTL
============

Name: sqrt_hs

Overview:
- Parametrised iterative integer square root with valid/ready handshakes on input and output.
- Adds output backpressure, a selectable round-to-nearest mode and saturation/overflow flagging, none of which the current start/complete square root unit has.
- Computes one root bit per clock using the non-restoring digit recurrence.
- Sits between an operand producer and a result consumer in the arithmetic datapath.

Parameters:
N, 16, root width in bits; radicand width is 2N, remainder width is N+1; legal range 2..32

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  radicand/round_mode valid
in_ready  output  1  block can accept an operand
radicand  input  2N  unsigned operand a
round_mode  input  1  0 = floor, 1 = round to nearest (ties impossible for integers)
out_valid  output  1  result valid, held until consumed
out_ready  input  1  consumer accepts result
root  output  N  result root
remainder  output  N+1  a - floor_root^2, always the floor remainder
rounded_up  output  1  root = floor_root + 1 was applied
ovf  output  1  round-up saturated at 2^N-1
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0) forces IDLE. Values while in reset:
  - in_ready=1, out_valid=0, busy=0;
  - root=0, remainder=0, rounded_up=0, ovf=0;
  - all internal working registers are cleared.
- Reset mid-operation: any operation in progress is discarded. No out_valid follows until a new acceptance.
- FSM states:
  - IDLE: in_ready=1. Acceptance on a rising edge with in_valid&&in_ready. Latch radicand and round_mode, clear partial root/remainder, load iteration counter with N-1, go to CALC.
  - CALC: in_ready=0. Each edge resolves one root bit, MSB first, consuming two radicand bits. The working remainder is signed N+2 bits: subtract (root<<2|1) when it is non-negative, otherwise add (root<<2|3). After the edge with counter=0, go to FIX.
  - FIX: one edge. If the final working remainder is negative, add (root<<1|1) to restore it. Form floor_root and the floor remainder. Apply rounding, register all outputs, set out_valid=1, go to DONE.
  - DONE: outputs stable while out_valid=1 && out_ready=0. On an edge with out_ready=1: out_valid→0, state→IDLE. in_ready stays 0 in DONE; no same-cycle accept.
- Latency and throughput:
  - Acceptance at edge E0; out_valid goes high after edge E(N+1). Latency is N+1 cycles.
  - Minimum issue interval is N+3 cycles with out_ready tied high.
- Rounding (round_mode latched at acceptance):
  - Condition is rem > floor_root, which is equivalent to a ≥ r²+r+1.
  - If the condition holds: root = floor_root+1, rounded_up=1.
  - If floor_root = 2^N-1 and the condition holds: root = 2^N-1, ovf=1, rounded_up=0.
  - round_mode=0: root = floor_root, rounded_up=0, ovf=0.
- Width rules:
  - Remainder never exceeds 2·floor_root, so it fits in N+1 bits.
  - Nothing is truncated silently.
- Input changes:
  - Changes on radicand/round_mode outside the acceptance edge have no effect.
  - in_valid held high across DONE is accepted on the first edge after returning to IDLE.
- Flag outputs (rounded_up, ovf, remainder, root) retain their last values after consumption until the next FIX edge.

Test Plan:
- N=16, a=0xFFFF_FFFF, round_mode=0 -> root=0xFFFF, remainder=0x1FFFE, rounded_up=0, ovf=0; out_valid rises exactly 17 cycles after acceptance.
- N=16, a=0xFFFF_FFFF, round_mode=1 -> root=0xFFFF, ovf=1, rounded_up=0, remainder=0x1FFFE.
- N=16 rounding and low-end corners:
  - a=24, mode 1 -> root=5, remainder=8, rounded_up=1.
  - a=20, mode 1 -> root=4, remainder=4, rounded_up=0.
  - a=0 -> root=0, remainder=0.
  - a=1 -> root=1, remainder=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Outputs stay constant, in_ready stays 0 and a new in_valid is ignored. After out_ready=1 for one edge: out_valid=0 and in_ready=1.
- Reset mid-CALC: assert rst_n=0 for 2 cycles at iteration 7. All outputs take reset values immediately (async) and no stale out_valid appears. A following a=144 gives root=12, remainder=0.
- Back-to-back random sweep: 10k random radicands with random round_mode and out_ready. Check every result against the reference model floor_root²+rem=a, rem≤2·floor_root, plus the rounding/ovf rules. Repeat with N=4 and N=32.

Source files
------------

// File: rtl/sqrt_hs.sv
// sqrt_hs: iterative integer square root, one root bit per clock via the
// non-restoring digit recurrence, wrapped in valid/ready handshakes.
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid && ready are both high. The producer may change radicand/round_mode
// freely at any other time; only the acceptance edge latches them. out_valid,
// once high, stays high with stable outputs until an edge with out_ready=1.
module sqrt_hs #(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   radicand,
  input  logic             round_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     root,
  output logic [N:0]       remainder,
  output logic             rounded_up,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2*N-1:0]   rad_q, rad_d;     // radicand, shifted left two bits per step
  logic [N+1:0]     wrem_q, wrem_d;   // signed working remainder
  logic [N-1:0]     part_q, part_d;   // partial root, grows one bit per step
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [N-1:0]     root_q, root_d;
  logic [N:0]       rem_q, rem_d;
  logic             ru_q, ru_d;
  logic             ovf_q, ovf_d;

  // Recurrence step. The working remainder is proven to fit in N+2 signed
  // bits, so the shifted-in value can be formed modulo 2^(N+2).
  logic [N+1:0]     shifted;
  logic [N+1:0]     step_rem;
  logic             step_bit;
  // Restore step: the corrected remainder is non-negative and below 2^(N+1).
  logic [N:0]       fix_rem;
  logic             round_cond;
  logic [N-1:0]     root_inc;

  assign shifted  = {wrem_q[N-1:0], rad_q[2*N-1 -: 2]};
  assign step_rem = wrem_q[N+1] ? (shifted + {part_q, 2'b11})
                                : (shifted - {part_q, 2'b01});
  assign step_bit = ~step_rem[N+1];

  assign fix_rem    = wrem_q[N+1] ? (wrem_q[N:0] + {part_q, 1'b1}) : wrem_q[N:0];
  assign round_cond = fix_rem > {1'b0, part_q};
  assign root_inc   = part_q + {{(N-1){1'b0}}, 1'b1};

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;
  assign root       = root_q;
  assign remainder  = rem_q;
  assign rounded_up = ru_q;
  assign ovf        = ovf_q;

  // Next-state and datapath update for every register, defaults first.
  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    wrem_d  = wrem_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    root_d  = root_q;
    rem_d   = rem_q;
    ru_d    = ru_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rad_d   = radicand;
          mode_d  = round_mode;
          wrem_d  = '0;
          part_d  = '0;
          cnt_d   = CW'(N - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        rad_d  = {rad_q[2*N-3:0], 2'b00};
        wrem_d = step_rem;
        part_d = {part_q[N-2:0], step_bit};
        cnt_d  = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        rem_d  = fix_rem;
        root_d = part_q;
        ru_d   = 1'b0;
        ovf_d  = 1'b0;
        if (mode_q && round_cond) begin
          if (&part_q) begin
            ovf_d = 1'b1;              // round-up would wrap: saturate
          end else begin
            root_d = root_inc;
            ru_d   = 1'b1;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rad_q   <= '0;
      wrem_q  <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      root_q  <= '0;
      rem_q   <= '0;
      ru_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      wrem_q  <= wrem_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      ru_q    <= ru_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
